// File: rtl/ahb_man_dummy.sv
// AHB-Lite manager: single-transfer commands in, AHB address/data phases out, one response pulse per transfer.
// Latency: accept edge N -> NONSEQ N+1 -> data N+2 -> rspValid N+3; wait states stretch either phase.
// Backpressure: cmdReady only (no response backpressure). Define AHB_MAN_PIPELINE_EN to overlap address and data phases.
module ahb_man_dummy #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [AddrWidth-1:0] cmdAddr,
  input  logic                 cmdWrite,
  input  logic [2:0]           cmdSize,
  input  logic [DataWidth-1:0] cmdData,
  output logic [AddrWidth-1:0] addr,
  output logic [1:0]           trans,
  output logic                 write,
  output logic [3:0]           control,
  output logic                 sel,
  output logic [DataWidth-1:0] wData,
  input  logic [DataWidth-1:0] rData,
  input  logic [1:0]           resp,
  input  logic                 ready,
  output logic                 rspValid,
  output logic [DataWidth-1:0] rspData,
  output logic                 rspErr
);

  logic                 addrPend;
  logic                 dataPend;
  logic                 dataWrite;
  logic [2:0]           sizeQ;
  logic [DataWidth-1:0] cmdDataQ;
  logic                 cmdAccept;
  logic                 addrDone;
  logic                 dataDone;

  // cmdReady is forced low while reset is held so nothing is taken during reset.
`ifdef AHB_MAN_PIPELINE_EN
  assign cmdReady = nReset & (!addrPend | ready);
`else
  assign cmdReady = nReset & !addrPend & !dataPend;
`endif

  assign cmdAccept = cmdValid & cmdReady;
  assign addrDone  = addrPend & ready;
  assign dataDone  = dataPend & ready;

  assign trans   = addrPend ? 2'b10 : 2'b00;
  assign sel     = addrPend;
  assign control = {1'b0, sizeQ};

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      addrPend  <= 1'b0;
      dataPend  <= 1'b0;
      dataWrite <= 1'b0;
      addr      <= '0;
      write     <= 1'b0;
      sizeQ     <= 3'd0;
      cmdDataQ  <= '0;
      wData     <= '0;
      rspValid  <= 1'b0;
      rspData   <= '0;
      rspErr    <= 1'b0;
    end else begin
      rspValid <= dataDone;
      if (dataDone) begin
        rspData <= dataWrite ? '0 : rData;
        rspErr  <= |resp;
      end

      // A new command may replace the address stage in the same edge the old one retires.
      if (cmdAccept) begin
        addrPend <= 1'b1;
        addr     <= cmdAddr;
        write    <= cmdWrite;
        sizeQ    <= cmdSize;
        cmdDataQ <= cmdData;
      end else if (addrDone) begin
        addrPend <= 1'b0;
      end

      if (addrDone) begin
        dataPend  <= 1'b1;
        dataWrite <= write;
        wData     <= cmdDataQ;
      end else if (dataDone) begin
        dataPend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_man_dummy.sv
// Directed self-checking bench for ahb_man_dummy; a small reactive subordinate model drives ready/resp/rData.
`timescale 1ns/1ps
module tb_ahb_man_dummy;

`ifdef AHB_MAN_PIPELINE_EN
  localparam int STEP = 1;
  localparam int ERR_NEXT_RSP = 5;
`else
  localparam int STEP = 3;
  localparam int ERR_NEXT_RSP = 7;
`endif

  logic        clk = 1'b0;
  logic        nReset;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdAddr;
  logic        cmdWrite;
  logic [2:0]  cmdSize;
  logic [31:0] cmdData;
  logic [31:0] addr;
  logic [1:0]  trans;
  logic        write;
  logic [3:0]  control;
  logic        sel;
  logic [31:0] wData;
  logic [31:0] rData;
  logic [1:0]  resp;
  logic        ready;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;

  int checks = 0;
  int failures = 0;

  // Command list and subordinate behaviour for run_cmds.
  logic [31:0] q_addr[$];
  logic        q_write[$];
  logic [31:0] q_data[$];
  logic [31:0] err_addr;
  logic [31:0] wait_addr;
  int          wait_n;
  logic [31:0] rd_val;

  // Observations recorded by run_cmds.
  int          ns_cyc[$];
  logic [31:0] ns_addr[$];
  logic [4:0]  ns_ctl[$];
  int          rsp_cyc[$];
  logic        rsp_err[$];
  logic [31:0] rsp_dat[$];
  int          wd_cyc[$];
  logic [31:0] wd_dat[$];

  ahb_man_dummy #(.AddrWidth(32), .DataWidth(32)) dut (
    .clk(clk), .nReset(nReset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddr(cmdAddr),
    .cmdWrite(cmdWrite), .cmdSize(cmdSize), .cmdData(cmdData),
    .addr(addr), .trans(trans), .write(write), .control(control), .sel(sel),
    .wData(wData), .rData(rData), .resp(resp), .ready(ready),
    .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr)
  );

  always #5 clk = ~clk;

  task automatic clear_cmds();
    q_addr.delete(); q_write.delete(); q_data.delete();
    err_addr = 32'hFFFF_FF00; wait_addr = 32'hFFFF_FF00; wait_n = 0; rd_val = 32'h0;
  endtask

  // Cycle 0 is the first negedge with the first command offered; called and returns at posedge+1.
  task automatic run_cmds(input int ncyc);
    int          idx = 0;
    logic        in_dph = 1'b0;
    logic [31:0] da = '0;
    int          dcnt = 0;
    logic        ns;
    logic [31:0] a;
    logic        cr;
    ns_cyc.delete(); ns_addr.delete(); ns_ctl.delete();
    rsp_cyc.delete(); rsp_err.delete(); rsp_dat.delete();
    wd_cyc.delete(); wd_dat.delete();
    ready = 1'b1; resp = 2'b00; rData = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < q_addr.size()) begin
        cmdValid = 1'b1; cmdAddr = q_addr[idx]; cmdWrite = q_write[idx];
        cmdData = q_data[idx]; cmdSize = 3'd2;
      end else begin
        cmdValid = 1'b0;
      end
      @(negedge clk);
      ns = (trans == 2'b10) && sel;
      a  = addr;
      cr = cmdReady;
      if (ns && ready) begin
        ns_cyc.push_back(c); ns_addr.push_back(a); ns_ctl.push_back({write, control});
      end
      if (in_dph && ready) begin
        wd_cyc.push_back(c); wd_dat.push_back(wData);
      end
      if (rspValid) begin
        rsp_cyc.push_back(c); rsp_err.push_back(rspErr); rsp_dat.push_back(rspData);
      end
      @(posedge clk); #1;
      if (cmdValid && cr) idx++;
      if (ready) begin
        in_dph = ns; da = a; dcnt = 0;
      end else begin
        dcnt++;
      end
      ready = 1'b1; resp = 2'b00; rData = '0;
      if (in_dph) begin
        rData = rd_val;
        if (da == err_addr) begin
          resp = 2'b01; ready = (dcnt >= 1);
        end else if (da == wait_addr) begin
          ready = (dcnt >= wait_n);
        end
      end
    end
    cmdValid = 1'b0; ready = 1'b1; resp = 2'b00; rData = '0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({trans, sel, addr, write, control, wData, rspValid, rspData, rspErr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: trans=%b sel=%b addr=%h write=%b control=%h wData=%h rspValid=%b rspData=%h rspErr=%b, required all zero",
               trans, sel, addr, write, control, wData, rspValid, rspData, rspErr);
    end
    checks++;
    if (cmdReady !== 1'b0) begin
      failures++; $display("FAIL reset_cmdReady: got %b required 0", cmdReady);
    end
    @(posedge clk); #1 nReset = 1'b1;
  endtask

  task automatic test_write();
    clear_cmds();
    q_addr.push_back(32'h100); q_write.push_back(1'b1); q_data.push_back(32'hDEADBEEF);
    run_cmds(8);
    checks++;
    if (ns_cyc.size() != 1 || ns_cyc[0] != 1 || ns_addr[0] !== 32'h100 || ns_ctl[0] !== 5'b10010) begin
      failures++; $display("FAIL write_addr_phase: nonseq count=%0d (cycle/addr/ctl of first shown if any), required 1 at cycle 1 addr 100 ctl 10010",
                           ns_cyc.size());
    end
    checks++;
    if (wd_cyc.size() != 1 || wd_cyc[0] != 2 || wd_dat[0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL write_wdata: count=%0d, required wData=deadbeef in cycle 2", wd_cyc.size());
    end
    checks++;
    if (rsp_cyc.size() != 1 || rsp_cyc[0] != 3 || rsp_err[0] !== 1'b0 || rsp_dat[0] !== 32'h0) begin
      failures++; $display("FAIL write_rsp: pulses=%0d, required one pulse in cycle 3 with err=0 data=0", rsp_cyc.size());
    end
  endtask

  task automatic test_read_wait();
    clear_cmds();
    rd_val = 32'h12345678;
    q_addr.push_back(32'h204); q_write.push_back(1'b0); q_data.push_back(32'h0);
    run_cmds(8);
    checks++;
    if (rsp_cyc.size() != 1 || rsp_cyc[0] != 3 || rsp_dat[0] !== 32'h12345678 || rsp_err[0] !== 1'b0) begin
      failures++; $display("FAIL read_nowait: pulses=%0d, required one pulse in cycle 3 data=12345678", rsp_cyc.size());
    end
    clear_cmds();
    rd_val = 32'h12345678; wait_addr = 32'h200; wait_n = 2;
    q_addr.push_back(32'h200); q_write.push_back(1'b0); q_data.push_back(32'h0);
    run_cmds(10);
    checks++;
    if (rsp_cyc.size() != 1) begin
      failures++; $display("FAIL read_wait_count: pulses=%0d required 1", rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_cyc[0] != 5 || rsp_dat[0] !== 32'h12345678 || rsp_err[0] !== 1'b0) begin
        failures++; $display("FAIL read_wait_rsp: cycle=%0d data=%h err=%b, required cycle 5 data=12345678 err=0",
                             rsp_cyc[0], rsp_dat[0], rsp_err[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    clear_cmds();
    for (int i = 0; i < 4; i++) begin
      q_addr.push_back(32'(4 * i)); q_write.push_back(1'b1); q_data.push_back(dat[i]);
    end
    run_cmds(18);
    checks++;
    if (ns_cyc.size() != 4 || rsp_cyc.size() != 4 || wd_dat.size() != 4) begin
      failures++; $display("FAIL b2b_counts: nonseq=%0d rsp=%0d wdata=%0d, required 4 each",
                           ns_cyc.size(), rsp_cyc.size(), wd_dat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ns_cyc[i] != 1 + i * STEP || ns_addr[i] !== 32'(4 * i)) begin
          failures++; $display("FAIL b2b_nonseq[%0d]: cycle=%0d addr=%h, required cycle %0d addr %h",
                               i, ns_cyc[i], ns_addr[i], 1 + i * STEP, 4 * i);
        end
        checks++;
        if (rsp_cyc[i] != 3 + i * STEP || rsp_err[i] !== 1'b0 || rsp_dat[i] !== 32'h0 || wd_dat[i] !== dat[i]) begin
          failures++; $display("FAIL b2b_rsp[%0d]: cycle=%0d err=%b data=%h wData=%h, required cycle %0d err 0 data 0 wData %h",
                               i, rsp_cyc[i], rsp_err[i], rsp_dat[i], wd_dat[i], 3 + i * STEP, dat[i]);
        end
      end
    end
  endtask

  task automatic test_error();
    clear_cmds();
    err_addr = 32'h300; rd_val = 32'hCAFEF00D;
    q_addr.push_back(32'h300); q_write.push_back(1'b0); q_data.push_back(32'h0);
    q_addr.push_back(32'h304); q_write.push_back(1'b1); q_data.push_back(32'h55AA55AA);
    run_cmds(14);
    checks++;
    if (rsp_cyc.size() != 2) begin
      failures++; $display("FAIL err_count: pulses=%0d required 2", rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_cyc[0] != 4 || rsp_err[0] !== 1'b1) begin
        failures++; $display("FAIL err_first: cycle=%0d err=%b, required cycle 4 err 1", rsp_cyc[0], rsp_err[0]);
      end
      checks++;
      if (rsp_cyc[1] != ERR_NEXT_RSP || rsp_err[1] !== 1'b0) begin
        failures++; $display("FAIL err_next: cycle=%0d err=%b, required cycle %0d err 0",
                             rsp_cyc[1], rsp_err[1], ERR_NEXT_RSP);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int first = -1;
    cmdValid = 1'b1; cmdAddr = 32'h200; cmdWrite = 1'b0; cmdSize = 3'd2; cmdData = 32'h0; ready = 1'b1;
    @(posedge clk); #1 cmdValid = 1'b0;
    @(posedge clk); #1 ready = 1'b0;
    @(posedge clk); #2 nReset = 1'b0;
    #1;
    checks++;
    if ({trans, sel, addr, write, control, wData, rspValid, rspData, rspErr, cmdReady} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: trans=%b sel=%b addr=%h write=%b control=%h wData=%h rspValid=%b cmdReady=%b, required all zero",
               trans, sel, addr, write, control, wData, rspValid, cmdReady);
    end
    @(posedge clk); #1;
    nReset = 1'b1; ready = 1'b1;
    cmdValid = 1'b1; cmdAddr = 32'h208;
    @(negedge clk);
    checks++;
    if (cmdReady !== 1'b1) begin
      failures++; $display("FAIL midreset_ready: cmdReady=%b required 1", cmdReady);
    end
    @(posedge clk); #1 cmdValid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (trans !== 2'b10 || addr !== 32'h208) begin
          failures++; $display("FAIL midreset_first_cmd: trans=%b addr=%h, required 10 and 208", trans, addr);
        end
      end
      if (rspValid) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (pulses != 1 || first != 3) begin
      failures++; $display("FAIL midreset_rsp: pulses=%0d first=%0d, required 1 pulse at cycle 3", pulses, first);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addr_hold();
    int bad = 0;
    cmdValid = 1'b1; cmdAddr = 32'h40; cmdWrite = 1'b1; cmdSize = 3'd1; cmdData = 32'hA5; ready = 1'b1;
    @(posedge clk); #1;
    cmdValid = 1'b0; ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (trans !== 2'b10 || sel !== 1'b1 || addr !== 32'h40 || write !== 1'b1 || control !== 4'b0001 || cmdReady !== 1'b0) begin
        failures++; bad++;
        $display("FAIL addr_hold[%0d]: trans=%b sel=%b addr=%h write=%b control=%b cmdReady=%b, required 10 1 40 1 0001 0",
                 k, trans, sel, addr, write, control, cmdReady);
      end
    end
    @(posedge clk); #1 ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    nReset = 1'b0; cmdValid = 1'b0; cmdAddr = '0; cmdWrite = 1'b0; cmdSize = 3'd0; cmdData = '0;
    rData = '0; resp = 2'b00; ready = 1'b1;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_addr_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_man_dummy.md
# ahb_man_dummy

AHB-Lite manager (initiator) that turns single-transfer commands from a bench or simple master into AHB address/data phases, honours subordinate wait states and error responses, and returns read data and status. It sits at the manager end of the AHB bus, driving the same signal set the subordinate dummies consume. Its main use is exercising subordinates in DV and acting as a minimal bus master in integration tops.

## Interface
- AddrWidth, 32, address bus width
- DataWidth, 32, data bus width (8/16/32/64)
- clk  input  1  clock; all logic rising-edge
- nReset  input  1  asynchronous active-low reset
- cmdValid  input  1  command offered
- cmdReady  output  1  command accepted on clk edge when cmdValid & cmdReady
- cmdAddr  input  AddrWidth  transfer address
- cmdWrite  input  1  1=write, 0=read
- cmdSize  input  3  HSIZE encoding (0=byte … 3=dword); must be ≤ log2(DataWidth/8)
- cmdData  input  DataWidth  write data
- addr  output  AddrWidth  AHB address
- trans  output  2  AHB HTRANS (IDLE=00, NONSEQ=10 only)
- write  output  1  AHB HWRITE
- control  output  4  {1'b0, size[2:0]}
- sel  output  1  subordinate select, high with NONSEQ address phase
- wData  output  DataWidth  write data, valid in data phase
- rData  input  DataWidth  read data from subordinate
- resp  input  2  00=OKAY, 01=ERROR
- ready  input  1  HREADY from selected subordinate
- rspValid  output  1  one-cycle pulse: transfer completed
- rspData  output  DataWidth  captured rData (0 for writes)
- rspErr  output  1  transfer ended with ERROR

## Operation
- Two registered stage flags: addrPend (address phase on bus), dataPend (data phase outstanding).
- Accept: cmd captured on edge; next cycle trans=NONSEQ, sel=1, addr/write/control from cmd.
- Address phase ends on first edge with ready=1; command moves to data stage, wData driven from captured cmdData from the next cycle until data phase completes.
- Data phase completes on edge with ready=1; rspValid pulses the following cycle with rspData=rData (reads) or 0 (writes), rspErr=(resp==01).
- No response backpressure; the consumer must take every rspValid pulse.
- Error: first ERROR cycle (ready=0, resp=01) ignored beyond holding; completion on second cycle (ready=1) reports rspErr=1. A following pipelined transfer is not cancelled and proceeds normally.
- resp=1x treated as ERROR.
- When no address phase is pending: trans=IDLE, sel=0, addr/write/control hold last values.

## Timing
- Reset (nReset=0): trans=00, sel=0, addr=0, write=0, control=0, wData=0, rspValid=0, rspData=0, rspErr=0, cmdReady=0, addrPend=dataPend=0.
- Reset mid-transfer: outstanding phases discarded, no rspValid issued; first command accepted on the first edge after nReset deasserts.
- Zero-wait-state latency: accept edge N, NONSEQ in cycle N+1, data phase N+2, rspValid in cycle N+3.
- Each wait cycle (ready=0) in either phase adds one cycle; all AHB outputs held stable while ready=0.
- cmdReady combinational from registered state and ready (see Configuration); never depends on cmdValid.

## Configuration
- AHB_MAN_PIPELINE_EN defined: cmdReady = !addrPend | ready; next command's address phase overlaps current data phase; back-to-back zero-wait transfers sustain one per cycle.
- Undefined: cmdReady = !addrPend & !dataPend; one transfer outstanding; at least one IDLE cycle between consecutive NONSEQ cycles; throughput one per 3 cycles at zero wait.

## Test plan
- Write 0xDEADBEEF to 0x100, size 2, ready=1 -> NONSEQ/addr=0x100/write=1 cycle N+1, wData=0xDEADBEEF cycle N+2, rspValid N+3, rspErr=0, rspData=0.
- Read 0x200 with ready=0 for 2 data-phase cycles, rData=0x12345678 -> rspValid exactly 2 cycles later than zero-wait case, rspData=0x12345678.
- PIPELINE_EN: 4 writes to 0x0,0x4,0x8,0xC with cmdValid held -> 4 consecutive NONSEQ cycles, 4 consecutive rspValid pulses; without macro -> IDLE between each, pulses 3 cycles apart.
- Two-cycle ERROR response on read -> rspValid once, rspErr=1; pipelined next transfer completes with rspErr=0.
- Assert nReset=0 during data phase wait state -> all outputs to reset values immediately, no rspValid after release.
- ready=0 held 5 cycles in address phase -> addr/trans/write/control/sel stable throughout, cmdReady=0 (both configs).
